uart_fifoed_send_param: RTL and testbench

Parametrised FIFO-buffered UART transmitter, the successor to the fixed 8N1 / 4096-entry sender.
- Adds configurable baud divisor, data width, parity, stop bits, FIFO depth and almost-full threshold.
- Adds a valid/ready write handshake, fill-level output, busy flag and overflow pulse.
- Sits between the on-chip producer (logger, command responder) and the board TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 73 +++++++
 rtl/uart_fifoed_send_param.sv | 178 +++++++++++++++++
 tb/tb_uart_fifoed_send_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised FIFO-buffered UART transmitter:
// parity modes, TX state encoding and the baud divisor helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with registered level and status flags.
// The head word is always visible on dout, so a pop and its data use the same edge.
module uart_sync_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             afull,
  output logic             full
);

  localparam logic [AW:0] AFULL_LVL = AW'(0) + (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg, level_next;
  logic             empty_reg, afull_reg, full_reg;
  logic             do_push, do_pop;

  assign do_push = push && !full_reg;
  assign do_pop  = pop && !empty_reg;

  always_comb begin
    level_next = level_reg;
    if (do_push && !do_pop)
      level_next = level_reg + (AW+1)'(1);
    else if (do_pop && !do_push)
      level_next = level_reg - (AW+1)'(1);
  end

  // Storage carries no reset; only pointers and level define its contents.
  always_ff @(posedge clk_100MHz) begin
    if (do_push)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      empty_reg  <= 1'b1;
      afull_reg  <= 1'b0;
      full_reg   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
      empty_reg <= (level_next == '0);
      afull_reg <= (level_next >= AFULL_LVL);
      full_reg  <= (level_next == FULL_LVL);
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign level = level_reg;
  assign empty = empty_reg;
  assign afull = afull_reg;
  assign full  = full_reg;

endmodule

// File: rtl/uart_fifoed_send_param.sv
// FIFO-buffered UART transmitter with configurable divisor, width, parity and stop bits.
// Frames leave back to back: the last stop cycle pops the next word straight into START.
module uart_fifoed_send_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV      = calc_div(100_000_000, 115_200),
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_THRESH = 12,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 s_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 fifo_empty,
  output logic                 fifo_afull,
  output logic                 fifo_full,
  output logic [LW-1:0]        fifo_level,
  output logic                 overflow
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("CLK_DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("DATA_BITS must be in 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
    $error("AFULL_THRESH must be in 1..FIFO_DEPTH");
  end

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_INV   = (PARITY == PAR_ODD);

  tx_state_t            state_reg;
  logic [CW-1:0]        baud_reg;
  logic [BW-1:0]        bit_reg;
  logic                 stop_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_reg, tx_reg, busy_reg, ovf_reg;
  logic [DATA_BITS-1:0] head;
  logic                 bit_done, frame_done, push, pop;

  assign s_ready    = !fifo_full;
  assign push       = s_valid && s_ready && !reset;
  assign bit_done   = (baud_reg == '0);
  assign frame_done = (state_reg == ST_STOP) && bit_done && (stop_reg == STOP_LAST);
  assign pop        = !fifo_empty && ((state_reg == ST_IDLE) || frame_done);

  uart_sync_fifo #(
    .WIDTH        (DATA_BITS),
    .DEPTH        (FIFO_DEPTH),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_fifo (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .push       (push),
    .din        (s_data),
    .pop        (pop),
    .dout       (head),
    .level      (fifo_level),
    .empty      (fifo_empty),
    .afull      (fifo_afull),
    .full       (fifo_full)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      stop_reg  <= 1'b0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      ovf_reg <= s_valid && !s_ready;
      if (pop) begin
        // Parity is latched with the word so PAR never looks back at the FIFO.
        state_reg <= ST_START;
        baud_reg  <= BAUD_LAST;
        shift_reg <= head;
        par_reg   <= (^head) ^ PAR_INV;
        tx_reg    <= 1'b0;
        busy_reg  <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
          end
          ST_START: begin
            if (bit_done) begin
              state_reg <= ST_DATA;
              baud_reg  <= BAUD_LAST;
              bit_reg   <= '0;
              tx_reg    <= shift_reg[0];
            end else begin
              baud_reg <= baud_reg - CW'(1);
            end
          end
          ST_DATA: begin
            if (bit_done) begin
              baud_reg  <= BAUD_LAST;
              shift_reg <= shift_reg >> 1;
              if (bit_reg == BIT_LAST) begin
                if (PARITY != PAR_NONE) begin
                  state_reg <= ST_PAR;
                  tx_reg    <= par_reg;
                end else begin
                  state_reg <= ST_STOP;
                  stop_reg  <= 1'b0;
                  tx_reg    <= 1'b1;
                end
              end else begin
                bit_reg <= bit_reg + BW'(1);
                tx_reg  <= shift_reg[1];
              end
            end else begin
              baud_reg <= baud_reg - CW'(1);
            end
          end
          ST_PAR: begin
            if (bit_done) begin
              state_reg <= ST_STOP;
              stop_reg  <= 1'b0;
              baud_reg  <= BAUD_LAST;
              tx_reg    <= 1'b1;
            end else begin
              baud_reg <= baud_reg - CW'(1);
            end
          end
          ST_STOP: begin
            if (bit_done) begin
              if (stop_reg == STOP_LAST) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
                tx_reg    <= 1'b1;
              end else begin
                stop_reg <= 1'b1;
                baud_reg <= BAUD_LAST;
              end
            end else begin
              baud_reg <= baud_reg - CW'(1);
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx       = tx_reg;
  assign tx_busy  = busy_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_uart_fifoed_send_param.sv
// Bench for uart_fifoed_send_param: a frame-level model of an 8N1 instance checked every
// cycle, plus two parity/2-stop instances checked against hand-built bit sequences.
module tb_uart_fifoed_send_param;

  localparam int CLK_DIV = 4;
  localparam int FRAME_A = 40;

  logic clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic       reset;
  logic       a_valid, a_ready, a_tx, a_busy, a_empty, a_afull, a_full, a_ovf;
  logic [7:0] a_data;
  logic [4:0] a_level;
  logic       p_valid;
  logic [7:0] p_data;
  logic       b_ready, b_tx, b_busy, b_empty, b_afull, b_full, b_ovf;
  logic [4:0] b_level;
  logic       c_ready, c_tx, c_busy, c_empty, c_afull, c_full, c_ovf;
  logic [4:0] c_level;

  uart_fifoed_send_param #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .FIFO_DEPTH(16), .AFULL_THRESH(12)
  ) dut_a (
    .clk_100MHz(clk_100MHz), .reset(reset), .s_valid(a_valid), .s_data(a_data),
    .s_ready(a_ready), .tx(a_tx), .tx_busy(a_busy), .fifo_empty(a_empty),
    .fifo_afull(a_afull), .fifo_full(a_full), .fifo_level(a_level), .overflow(a_ovf)
  );

  uart_fifoed_send_param #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
    .FIFO_DEPTH(16), .AFULL_THRESH(12)
  ) dut_b (
    .clk_100MHz(clk_100MHz), .reset(reset), .s_valid(p_valid), .s_data(p_data),
    .s_ready(b_ready), .tx(b_tx), .tx_busy(b_busy), .fifo_empty(b_empty),
    .fifo_afull(b_afull), .fifo_full(b_full), .fifo_level(b_level), .overflow(b_ovf)
  );

  uart_fifoed_send_param #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
    .FIFO_DEPTH(16), .AFULL_THRESH(12)
  ) dut_c (
    .clk_100MHz(clk_100MHz), .reset(reset), .s_valid(p_valid), .s_data(p_data),
    .s_ready(c_ready), .tx(c_tx), .tx_busy(c_busy), .fifo_empty(c_empty),
    .fifo_afull(c_afull), .fifo_full(c_full), .fifo_level(c_level), .overflow(c_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of dut_a: queue of accepted words, and a frame timer measured in cycles.
  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_busy = 0, m_start, m_room, m_tx = 1, m_ovf = 0;
  int         m_t = 0;
  int         m_accepted = 0;

  function automatic logic fbit(input logic [7:0] w, input int idx);
    logic [9:0] f;
    f = {1'b1, w, 1'b0};
    return f[idx];
  endfunction

  initial forever begin
    @(posedge clk_100MHz);
    if (reset) begin
      m_q.delete();
      m_busy = 0; m_t = 0; m_tx = 1; m_ovf = 0;
    end else begin
      m_room  = (m_q.size() < 16);
      m_start = 0;
      m_ovf   = a_valid && !m_room;
      if (!m_busy) begin
        m_start = (m_q.size() != 0);
      end else if (m_t == FRAME_A - 1) begin
        m_start = (m_q.size() != 0);
        m_busy  = m_start;
      end else begin
        m_t++;
      end
      if (m_start) begin
        m_cur = m_q.pop_front();
        m_busy = 1;
        m_t = 0;
      end
      if (a_valid && m_room) begin
        m_q.push_back(a_data);
        m_accepted++;
      end
      m_tx = m_busy ? fbit(m_cur, m_t / CLK_DIV) : 1'b1;
    end
  end

  initial begin
    @(posedge clk_100MHz);
    forever begin
      #1;
      check("tx", a_tx, m_tx);
      check("tx_busy", a_busy, m_busy);
      check("fifo_level", a_level, m_q.size());
      check("fifo_empty", a_empty, m_q.size() == 0);
      check("fifo_full", a_full, m_q.size() == 16);
      check("fifo_afull", a_afull, m_q.size() >= 12);
      check("s_ready", a_ready, m_q.size() < 16);
      check("overflow", a_ovf, m_ovf);
      @(posedge clk_100MHz);
    end
  end

  int ovf_cnt = 0;
  int busy_cnt = 0;
  initial forever begin
    @(negedge clk_100MHz);
    if (a_ovf) ovf_cnt++;
    if (a_busy) busy_cnt++;
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((a_busy || !a_empty) && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("drain_in_budget", n < budget, 1);
  endtask

  logic [11:0] exp_b, exp_c;
  logic [9:0]  exp_a;
  int          acc0;

  initial begin
    reset = 1'b1; a_valid = 1'b0; a_data = 8'h00; p_valid = 1'b0; p_data = 8'h00;
    repeat (3) @(negedge clk_100MHz);
    check("rst_tx", a_tx, 1);
    check("rst_busy", a_busy, 0);
    check("rst_level", a_level, 0);
    check("rst_empty", a_empty, 1);
    check("rst_afull", a_afull, 0);
    check("rst_ovf", a_ovf, 0);
    reset = 1'b0;
    @(negedge clk_100MHz);

    // Even and odd parity with two stop bits, word 0x07.
    exp_b = {2'b11, 1'b1, 8'h07, 1'b0};
    exp_c = {2'b11, 1'b0, 8'h07, 1'b0};
    p_valid = 1'b1; p_data = 8'h07;
    @(negedge clk_100MHz);
    p_valid = 1'b0;
    @(negedge clk_100MHz);
    for (int k = 0; k < 48; k++) begin
      check($sformatf("even_bit%0d", k / 4), b_tx, exp_b[k / 4]);
      check($sformatf("odd_bit%0d", k / 4), c_tx, exp_c[k / 4]);
      @(negedge clk_100MHz);
    end
    check("even_idle", b_busy, 0);
    check("odd_idle", c_busy, 0);

    // 8N1 frame of 0x55, checked against the literal line pattern.
    exp_a = {1'b1, 8'h55, 1'b0};
    a_valid = 1'b1; a_data = 8'h55;
    @(negedge clk_100MHz);
    a_valid = 1'b0;
    @(negedge clk_100MHz);
    for (int k = 0; k < 40; k++) begin
      check($sformatf("a55_bit%0d", k / 4), a_tx, exp_a[k / 4]);
      check("model_a55", m_tx, exp_a[k / 4]);
      @(negedge clk_100MHz);
    end
    check("a55_idle", a_busy, 0);

    // Hold s_valid for 20 edges: 17 accepted, 3 dropped.
    ovf_cnt = 0;
    acc0 = m_accepted;
    a_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_data = 8'(8'h10 + i);
      @(negedge clk_100MHz);
      if (i == 11) begin
        check("lvl11", a_level, 11);
        check("afull_at11", a_afull, 0);
      end
      if (i == 12) check("afull_at12", a_afull, 1);
      if (i == 16) begin
        check("lvl16", a_level, 16);
        check("full_at16", a_full, 1);
        check("ready_at16", a_ready, 0);
      end
    end
    a_valid = 1'b0;
    check("model_accepted17", m_accepted - acc0, 17);
    repeat (2) @(negedge clk_100MHz);
    check("ovf_pulses", ovf_cnt, 3);
    wait_idle(2000);

    // Three queued words go out back to back: 120 contiguous busy cycles.
    busy_cnt = 0;
    a_valid = 1'b1; a_data = 8'hA1;
    @(negedge clk_100MHz);
    a_data = 8'hB2;
    @(negedge clk_100MHz);
    a_data = 8'hC3;
    @(negedge clk_100MHz);
    a_valid = 1'b0;
    wait_idle(400);
    check("three_frames_busy", busy_cnt, 120);
    check("three_frames_empty", a_empty, 1);

    // Reset in the middle of the second of five frames.
    a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_data = 8'(8'h30 + i);
      @(negedge clk_100MHz);
    end
    a_valid = 1'b0;
    repeat (55) @(negedge clk_100MHz);
    check("pre_rst_busy", a_busy, 1);
    reset = 1'b1;
    @(negedge clk_100MHz);
    reset = 1'b0;
    check("mid_rst_tx", a_tx, 1);
    check("mid_rst_level", a_level, 0);
    check("mid_rst_busy", a_busy, 0);
    busy_cnt = 0;
    repeat (200) @(negedge clk_100MHz);
    check("no_frames_after_rst", busy_cnt, 0);

    // Push on the same edge as a frame-end pop with level 5.
    a_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_data = 8'(8'h60 + i);
      @(negedge clk_100MHz);
    end
    a_valid = 1'b0;
    repeat (35) @(negedge clk_100MHz);
    check("lvl5_before", a_level, 5);
    a_valid = 1'b1; a_data = 8'h6F;
    @(negedge clk_100MHz);
    a_valid = 1'b0;
    check("lvl5_after", a_level, 5);
    check("busy_after_pushpop", a_busy, 1);
    wait_idle(600);

    // 40 words through the 16-deep FIFO; order is checked by the model.
    acc0 = m_accepted;
    for (int i = 0; i < 40; i++) begin
      a_valid = 1'b1; a_data = 8'((i * 37 + 5) & 255);
      @(negedge clk_100MHz);
      a_valid = 1'b0;
      repeat (29) @(negedge clk_100MHz);
    end
    wait_idle(3000);
    check("model_accepted40", m_accepted - acc0, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
